// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data bus for LB/LH/LW/SB/SH/SW and forwards write-back fields.
// Optional build macro MEM_ALIGN_CHECK_EN adds misalign_o and traps misaligned word/half accesses.
module mem_access_stage #(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned ALUOP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        reg2_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        pc_i,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               stallreq_o,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [31:0]        dbus_addr_o,
  output logic [3:0]         dbus_sel_o,
  output logic [31:0]        dbus_wdata_o,
  input  logic [31:0]        dbus_rdata_i,
  input  logic               dbus_ack_i,
`ifdef MEM_ALIGN_CHECK_EN
  output logic               misalign_o,
`endif
  output logic               bus_err_o
);

  localparam logic [ALUOP_W-1:0] OpLb = ALUOP_W'(8'hE0);
  localparam logic [ALUOP_W-1:0] OpLh = ALUOP_W'(8'hE1);
  localparam logic [ALUOP_W-1:0] OpLw = ALUOP_W'(8'hE3);
  localparam logic [ALUOP_W-1:0] OpSb = ALUOP_W'(8'hE8);
  localparam logic [ALUOP_W-1:0] OpSh = ALUOP_W'(8'hE9);
  localparam logic [ALUOP_W-1:0] OpSw = ALUOP_W'(8'hEB);
  localparam logic [7:0]         CntLast = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  logic        is_load, is_store, is_mem, is_byte, is_half;
  logic [1:0]  a;
  logic [3:0]  lane_sel;
  logic [31:0] store_data, byte_sh, half_sh, load_ext;
  logic        unused_pc;

  assign unused_pc = ^pc_i;
  assign a         = mem_addr_i[1:0];
  assign is_load   = (aluop_i == OpLb) || (aluop_i == OpLh) || (aluop_i == OpLw);
  assign is_store  = (aluop_i == OpSb) || (aluop_i == OpSh) || (aluop_i == OpSw);
  assign is_mem    = is_load || is_store;
  assign is_byte   = (aluop_i == OpLb) || (aluop_i == OpSb);
  assign is_half   = (aluop_i == OpLh) || (aluop_i == OpSh);

  always_comb begin
    lane_sel   = 4'b1111;
    store_data = reg2_i;
    if (is_byte) begin
      lane_sel   = 4'b0001 << a;
      store_data = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      lane_sel   = 4'b0011 << {a[1], 1'b0};
      store_data = {2{reg2_i[15:0]}};
    end
  end

  // Address bits are still valid in DONE: upstream only advances at the end of that cycle.
  assign byte_sh = rdata_q >> {a, 3'b000};
  assign half_sh = rdata_q >> {a[1], 4'b0000};

  always_comb begin
    load_ext = rdata_q;
    if (aluop_i == OpLb)      load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
    else if (aluop_i == OpLh) load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (is_mem) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (((aluop_i == OpLw || aluop_i == OpSw) && a != 2'b00) || (is_half && a[0])) begin
            state_d = StDone;
            mis_d   = 1'b1;
          end else
`endif
          begin
            state_d = StBus;
            cnt_d   = 8'd0;
            addr_d  = {mem_addr_i[31:2], 2'b00};
            sel_d   = lane_sel;
            wdat_d  = store_data;
            we_d    = is_store;
          end
        end
      end
      StBus: begin
        cnt_d = cnt_q + 8'd1;
        // Ack takes priority over a timeout landing on the same cycle.
        if (dbus_ack_i) begin
          rdata_d = dbus_rdata_i;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    wd_o         = 5'd0;
    wreg_o       = 1'b0;
    wdata_o      = 32'd0;
    stallreq_o   = 1'b0;
    bus_err_o    = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = 32'd0;
    dbus_sel_o   = 4'd0;
    dbus_wdata_o = 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_o   = 1'b0;
`endif
    if (!rst) begin
      wd_o    = wd_i;
      wdata_o = wdata_i;
      unique case (state_q)
        StIdle: begin
          if (is_mem) stallreq_o = 1'b1;
          else        wreg_o     = wreg_i;
        end
        StBus: begin
          stallreq_o   = 1'b1;
          dbus_req_o   = 1'b1;
          dbus_we_o    = we_q;
          dbus_addr_o  = addr_q;
          dbus_sel_o   = sel_q;
          dbus_wdata_o = wdat_q;
        end
        StDone: begin
          bus_err_o = err_q;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_o = mis_q;
          if (is_load && !mis_q) begin
`else
          if (is_load) begin
`endif
            wreg_o  = wreg_i;
            wdata_o = load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-lane reference model.
module tb_mem_access_stage;
  localparam int unsigned Tmo = 4;
  localparam logic [7:0] OpLb = 8'hE0, OpLh = 8'hE1, OpLw = 8'hE3;
  localparam logic [7:0] OpSb = 8'hE8, OpSh = 8'hE9, OpSw = 8'hEB, OpAddu = 8'h21;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] aluop_i = 8'h0;
  logic [31:0] mem_addr_i = '0, reg2_i = '0, wdata_i = '0, pc_i = '0, dbus_rdata_i = '0;
  logic [4:0] wd_i = '0;
  logic wreg_i = 1'b0, dbus_ack_i = 1'b0;
  logic [4:0] wd_o;
  logic wreg_o, stallreq_o, dbus_req_o, dbus_we_o, bus_err_o;
  logic [31:0] wdata_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0] dbus_sel_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_o;
`endif
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.BUS_TIMEOUT(Tmo), .ALUOP_W(8)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .pc_i(pc_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .bus_err_o(bus_err_o)
  );

  // Reference model: access size in bytes, lanes covered, data per lane.
  function automatic int nbytes(input logic [7:0] op);
    if (op == OpLb || op == OpSb) return 1;
    if (op == OpLh || op == OpSh) return 2;
    return 4;
  endfunction

  function automatic bit is_load_op(input logic [7:0] op);
    return op == OpLb || op == OpLh || op == OpLw;
  endfunction

  function automatic bit is_mis(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return (addr % nbytes(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
    int n = nbytes(op);
    int base = (int'(addr % 4) / n) * n;
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) if (i >= base && i < base + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_store(input logic [7:0] op, input logic [31:0] d);
    int n = nbytes(op);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int n = nbytes(op);
    int base = (int'(addr % 4) / n) * n;
    logic [7:0] b;
    logic [15:0] h;
    if (n == 1) begin
      b = rd[8*base +: 8];
      return 32'($signed(b));
    end
    if (n == 2) begin
      h = rd[8*base +: 16];
      return 32'($signed(h));
    end
    return rd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] d2,
                         input logic [31:0] rd, input int ack_delay);
    bit ld = is_load_op(op);
    bit timed = ack_delay >= int'(Tmo);
    bit acked;
    aluop_i = op; mem_addr_i = addr; reg2_i = d2; wd_i = 5'($urandom); wreg_i = 1'b1;
    wdata_i = $urandom; dbus_ack_i = 1'b0;
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL idle_stall: got %b want 1", stallreq_o); end
    checks++; if (wreg_o !== 1'b0 || dbus_req_o !== 1'b0) begin errors++; $display("FAIL idle_wreg_req: got %b%b want 00", wreg_o, dbus_req_o); end
    step();
    if (is_mis(op, addr)) begin
      dbus_ack_i = 1'b1;
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign: got %b want 1", misalign_o); end
`endif
      checks++; if (dbus_req_o !== 1'b0 || wreg_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL mis_done: req/wreg/stall got %b%b%b want 000", dbus_req_o, wreg_o, stallreq_o); end
      step();
      dbus_ack_i = 1'b0;
      return;
    end
    for (int k = 0; k < int'(Tmo); k++) begin
      acked = (k == ack_delay);
      dbus_ack_i = acked;
      dbus_rdata_i = acked ? rd : $urandom;
      #1;
      checks++; if (dbus_req_o !== 1'b1 || stallreq_o !== 1'b1 || wreg_o !== 1'b0) begin errors++; $display("FAIL bus_ctl c%0d: req/stall/wreg got %b%b%b want 110", k, dbus_req_o, stallreq_o, wreg_o); end
      checks++; if (dbus_we_o !== !ld) begin errors++; $display("FAIL bus_we: got %b want %b", dbus_we_o, !ld); end
      checks++; if (dbus_addr_o !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL bus_addr: got %h want %h", dbus_addr_o, {addr[31:2], 2'b00}); end
      checks++; if (dbus_sel_o !== exp_sel(op, addr)) begin errors++; $display("FAIL bus_sel: got %b want %b", dbus_sel_o, exp_sel(op, addr)); end
      if (!ld) begin
        checks++; if (dbus_wdata_o !== exp_store(op, d2)) begin errors++; $display("FAIL bus_wdata: got %h want %h", dbus_wdata_o, exp_store(op, d2)); end
      end
      step();
      if (acked) break;
    end
    dbus_ack_i = 1'b0; dbus_rdata_i = $urandom;
    #1;
    checks++; if (stallreq_o !== 1'b0 || dbus_req_o !== 1'b0 || dbus_sel_o !== 4'b0) begin errors++; $display("FAIL done_ctl: stall/req/sel got %b%b%b want 000000", stallreq_o, dbus_req_o, dbus_sel_o); end
    checks++; if (bus_err_o !== timed) begin errors++; $display("FAIL bus_err: got %b want %b", bus_err_o, timed); end
    checks++; if (wreg_o !== ld) begin errors++; $display("FAIL done_wreg: got %b want %b", wreg_o, ld); end
    if (ld) begin
      checks++; if (wdata_o !== (timed ? 32'd0 : exp_load(op, addr, rd)) || wd_o !== wd_i) begin errors++; $display("FAIL load_data: got %h want %h", wdata_o, timed ? 32'd0 : exp_load(op, addr, rd)); end
    end
    step();
  endtask

  task automatic test_passthrough(input logic [31:0] d, input logic [4:0] rd, input logic we);
    aluop_i = OpAddu; wdata_i = d; wd_i = rd; wreg_i = we; mem_addr_i = $urandom;
    dbus_ack_i = 1'b1;
    #1;
    checks++; if (wd_o !== rd || wreg_o !== we || wdata_o !== d) begin errors++; $display("FAIL pass_wb: got %0d %b %h want %0d %b %h", wd_o, wreg_o, wdata_o, rd, we, d); end
    checks++; if (stallreq_o !== 1'b0 || dbus_req_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL pass_ctl: stall/req/err got %b%b%b want 000", stallreq_o, dbus_req_o, bus_err_o); end
    step();
    dbus_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    aluop_i = OpAddu; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if ({wd_o, wreg_o, wdata_o, stallreq_o, dbus_req_o, bus_err_o} !== '0) begin errors++; $display("FAIL reset_out: got %h %b %h want 0", wd_o, wreg_o, wdata_o); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    aluop_i = OpLw; mem_addr_i = 32'h3000; wreg_i = 1'b1; wd_i = 5'd3; dbus_ack_i = 1'b0;
    step();
    #1;
    checks++; if (dbus_req_o !== 1'b1) begin errors++; $display("FAIL mid_req_pre: got %b want 1", dbus_req_o); end
    rst = 1'b1;
    #1;
    checks++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0 || wreg_o !== 1'b0) begin errors++; $display("FAIL mid_rst: req/stall/wreg got %b%b%b want 000", dbus_req_o, stallreq_o, wreg_o); end
    step();
    rst = 1'b0; aluop_i = OpAddu; wreg_i = 1'b0; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0 || wreg_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL mid_after: req/stall/wreg/err got %b%b%b%b want 0000", dbus_req_o, stallreq_o, wreg_o, bus_err_o); end
      step();
    end
    dbus_ack_i = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] ops [7] = '{OpLb, OpLh, OpLw, OpSb, OpSh, OpSw, OpAddu};
    logic [7:0] op;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == OpAddu) test_passthrough($urandom, 5'($urandom), 1'($urandom));
      else run_mem(op, $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough(32'h0000_1234, 5'd5, 1'b1);
    run_mem(OpLb, 32'h1003, 32'h0, 32'h8000_0000, 1);
    run_mem(OpSh, 32'h2002, 32'hAAAA_BEEF, 32'h0, 0);
    run_mem(OpLw, 32'h3000, 32'h0, 32'h0, 99);
    test_passthrough(32'h0, 5'd0, 1'b0);
    run_mem(OpLh, 32'h5002, 32'h0, 32'h9ABC_0000, int'(Tmo) - 1);
    run_mem(OpSw, 32'h4001, 32'h1122_3344, 32'h0, 0);
    run_mem(OpSb, 32'h6001, 32'h0000_00A5, 32'h0, 2);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage that consumes the execute stage's outputs (aluop, mem_addr, reg2, wd, wreg, wdata, pc) and performs the data-memory side of LW/LB/LH/SW/SB/SH.
- Drives a request/acknowledge data bus.
- Holds the pipeline via stallreq_o until the access completes.
- Forwards write-back fields to the MEM/WB register.
- Non-memory ops pass straight through in the same cycle.

Parameters:
- BUS_TIMEOUT, 255: max cycles waiting for dbus_ack_i before the access is aborted (8-bit counter; values 1..255).
- ALUOP_W, 8: width of aluop_i (matches AluOpBus).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- aluop_i  in  ALUOP_W  op from execute stage.
- mem_addr_i  in  32  effective address.
- reg2_i  in  32  store data.
- wd_i  in  5  destination register.
- wreg_i  in  1  register write enable.
- wdata_i  in  32  ALU result.
- pc_i  in  32  instruction PC; reserved, unused in logic.
- wd_o  out  5  destination register to write-back.
- wreg_o  out  1  write enable to write-back.
- wdata_o  out  32  write-back data.
- stallreq_o  out  1  pipeline hold request.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1 = write.
- dbus_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
- dbus_sel_o  out  4  byte-lane enables.
- dbus_wdata_o  out  32  write data.
- dbus_rdata_i  in  32  read data, valid with ack.
- dbus_ack_i  in  1  access complete.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst=1, async): FSM=IDLE, timeout counter=0, captured data=0, all outputs 0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - Non-memory op: wd_o/wreg_o/wdata_o = wd_i/wreg_i/wdata_i combinationally; stallreq_o=0.
  - Memory op (LW, LB, LH, SW, SB, SH): stallreq_o=1 combinationally and wreg_o=0; next state BUS.
  - Address, lanes and store data are registered on entry to BUS. Upstream inputs are held stable while stallreq_o=1.
- BUS:
  - dbus_req_o=1 (registered), stallreq_o=1, wreg_o=0; counter increments each cycle.
  - dbus_ack_i=1: capture dbus_rdata_i, drop req the next cycle, go DONE. Ack in the first BUS cycle is legal, giving a minimum total latency of 3 cycles (IDLE, BUS, DONE).
  - Counter reaches BUS_TIMEOUT with no ack: drop req, captured data=0, go DONE with the error flag set.
  - If ack and timeout occur in the same cycle, ack wins and no error is flagged.
- DONE (exactly 1 cycle):
  - stallreq_o=0.
  - Loads: wreg_o=wreg_i, wd_o=wd_i, wdata_o=extended load data.
  - Stores: wreg_o=0.
  - bus_err_o=1 if timed out.
  - Next state IDLE. The upstream stage advances on this cycle, so the op is not reissued.
- Lane mapping (little-endian; a = mem_addr_i[1:0]):
  - Byte: sel = 4'b0001<<a; data lane = a.
  - Half: sel = 4'b0011<<{a[1],1'b0}.
  - Word: sel = 4'b1111.
- Loads: LB and LH sign-extend the selected lane(s); LW takes all 32 bits.
- Stores:
  - SB replicates reg2_i[7:0] into all 4 lanes.
  - SH replicates reg2_i[15:0] into both halves.
  - SW sends reg2_i.
- dbus_ack_i outside BUS is ignored.
- dbus_we_o, dbus_addr_o, dbus_sel_o and dbus_wdata_o are 0 whenever dbus_req_o=0.
- Reset mid-access: req drops immediately, FSM returns to IDLE, and no write-back occurs.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit).
  - LW/SW with a≠0, or LH/SH with a[0]=1, do not enter BUS. The stage goes directly IDLE→DONE with stallreq_o=1 for one cycle.
  - misalign_o pulses 1 in DONE, wreg_o=0, and no bus request is issued.
- When undefined: the low address bits of misaligned accesses are ignored per the lane mapping above, and the misalign_o port does not exist.

Test Plan:
- ADDU, wdata_i=0x0000_1234, wd_i=5, wreg_i=1 → same cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stallreq_o=0, dbus_req_o=0.
- LB, addr 0x1003, rdata 0x8000_0000, ack on 2nd BUS cycle → sel=4'b1000, addr_o=0x1000, stall for 3 cycles, DONE wdata_o=0xFFFF_FF80.
- SH, addr 0x2002, reg2_i=0xAAAA_BEEF, immediate ack → dbus_we_o=1, sel=4'b1100, wdata=0xBEEF_BEEF, DONE wreg_o=0.
- LW, addr 0x3000, ack never, BUS_TIMEOUT=4 → req high for 4 cycles then low, DONE wdata_o=0, bus_err_o pulses once, stallreq_o low in DONE.
- LW in BUS, rst pulsed for 1 cycle → dbus_req_o=0 and stallreq_o=0 immediately, no write-back; a later ack is ignored.
- With MEM_ALIGN_CHECK_EN: SW to 0x4001 → no dbus_req_o, misalign_o=1 for 1 cycle, wreg_o=0.
